// File: rtl/tdma_burst_scheduler.sv
// Purpose: TDMA slot/symbol/frame timing that fires bursts ahead of enabled slots and sequences PA enable.
// Latency: fire_burst_o and frame_start_o are registered on the deciding strobe edge; pa_enable_o follows PA state.
// Backpressure: none upstream; an unarmed or busy burst controller sets sticky underrun_o instead of stalling.
module tdma_burst_scheduler #(
  parameter int FIRE_LEAD  = 4,
  parameter int PA_LAG     = 2,
  parameter int IQ_TIMEOUT = 8,
  parameter int FN_WIDTH   = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                symbol_strobe_i,
  input  logic                enable_i,
  input  logic [7:0]          slot_mask_i,
  input  logic                mask_load_i,
  input  logic                is_armed_i,
  input  logic                iq_valid_i,
  output logic                fire_burst_o,
  output logic                pa_enable_o,
  output logic [2:0]          slot_number_o,
  output logic [7:0]          symbol_in_slot_o,
  output logic [FN_WIDTH-1:0] frame_number_o,
  output logic                frame_start_o,
  output logic                underrun_o
);

  typedef enum logic {RUN_IDLE, RUN_ACTIVE} run_state_t;
  typedef enum logic [1:0] {PA_OFF, PA_WAIT_IQ, PA_ON, PA_HOLD} pa_state_t;

  run_state_t run_state, run_next;
  pa_state_t  pa_state, pa_next;
  logic [7:0] pa_cnt, pa_cnt_next;
  logic       pa_timeout;

  logic [7:0] active_mask, shadow_mask, active_eff;
  logic       shadow_valid;

  logic       running, adv, sym_wrap, decide, commit, want, fire_ok, fire_fail;
  logic [7:0] slot_len;
  logic [2:0] target;

  // Slots 0 and 4 carry the extra symbol so a frame totals 1250 symbols.
  assign running   = (run_state == RUN_ACTIVE) && enable_i;
  assign adv       = running && symbol_strobe_i;
  assign slot_len  = (slot_number_o == 3'd0 || slot_number_o == 3'd4) ? 8'd157 : 8'd156;
  assign sym_wrap  = (symbol_in_slot_o == slot_len - 8'd1);
  assign target    = slot_number_o + 3'd1;
  assign decide    = adv && !sym_wrap &&
                     ((symbol_in_slot_o + 8'd1) == (slot_len - 8'(FIRE_LEAD)));
  // A new mask takes effect only at the decision for slot 0, and that decision already sees it.
  assign commit    = decide && (target == 3'd0) && shadow_valid;
  assign active_eff = commit ? shadow_mask : active_mask;
  assign want      = decide && active_eff[target];
  assign fire_ok   = want && is_armed_i && (pa_state == PA_OFF);
  assign fire_fail = want && !fire_ok;
  assign pa_enable_o = (pa_state != PA_OFF);

  // Run FSM state register.
  always_ff @(posedge clock) begin
    if (reset) run_state <= RUN_IDLE;
    else       run_state <= run_next;
  end

  // Run FSM next state: follows enable_i with one cycle of lag.
  always_comb begin
    run_next = run_state;
    case (run_state)
      RUN_IDLE:   if (enable_i)  run_next = RUN_ACTIVE;
      RUN_ACTIVE: if (!enable_i) run_next = RUN_IDLE;
      default:    run_next = RUN_IDLE;
    endcase
  end

  // Symbol/slot/frame counters; held at zero whenever the scheduler is not running.
  always_ff @(posedge clock) begin
    frame_start_o <= 1'b0;
    if (reset || !running) begin
      symbol_in_slot_o <= 8'd0;
      slot_number_o    <= 3'd0;
      frame_number_o   <= '0;
    end else if (adv) begin
      if (sym_wrap) begin
        symbol_in_slot_o <= 8'd0;
        slot_number_o    <= slot_number_o + 3'd1;
        if (slot_number_o == 3'd7) begin
          frame_number_o <= frame_number_o + FN_WIDTH'(1);
          frame_start_o  <= 1'b1;
        end
      end else begin
        symbol_in_slot_o <= symbol_in_slot_o + 8'd1;
      end
    end
  end

  // Shadow/active masks; a load coinciding with a commit stays pending for the next frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_mask  <= 8'd0;
      active_mask  <= 8'd0;
      shadow_valid <= 1'b0;
    end else begin
      if (commit) begin
        active_mask  <= shadow_mask;
        shadow_valid <= 1'b0;
      end
      if (mask_load_i) begin
        shadow_mask  <= slot_mask_i;
        shadow_valid <= 1'b1;
      end
    end
  end

  // Fire pulse and sticky underrun; a new fault wins over a same-cycle mask load clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      fire_burst_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      fire_burst_o <= fire_ok;
      if (fire_fail || pa_timeout) underrun_o <= 1'b1;
      else if (mask_load_i)        underrun_o <= 1'b0;
    end
  end

  // PA FSM state and strobe counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pa_state <= PA_OFF;
      pa_cnt   <= 8'd0;
    end else begin
      pa_state <= pa_next;
      pa_cnt   <= pa_cnt_next;
    end
  end

  // PA FSM next state: IQ timeout while waiting, lag hold after IQ ends or the scheduler stops.
  always_comb begin
    pa_next     = pa_state;
    pa_cnt_next = pa_cnt;
    pa_timeout  = 1'b0;
    case (pa_state)
      PA_OFF: begin
        if (fire_ok) begin
          pa_next     = PA_WAIT_IQ;
          pa_cnt_next = 8'd0;
        end
      end
      PA_WAIT_IQ: begin
        if (!enable_i) begin
          pa_next     = PA_HOLD;
          pa_cnt_next = 8'd0;
        end else if (iq_valid_i) begin
          pa_next = PA_ON;
        end else if (symbol_strobe_i) begin
          if (pa_cnt == 8'(IQ_TIMEOUT - 1)) begin
            pa_next    = PA_OFF;
            pa_timeout = 1'b1;
          end else begin
            pa_cnt_next = pa_cnt + 8'd1;
          end
        end
      end
      PA_ON: begin
        if (!enable_i || !iq_valid_i) begin
          pa_next     = PA_HOLD;
          pa_cnt_next = 8'd0;
        end
      end
      PA_HOLD: begin
        if (symbol_strobe_i) begin
          if (pa_cnt == 8'(PA_LAG - 1)) pa_next = PA_OFF;
          else                          pa_cnt_next = pa_cnt + 8'd1;
        end
      end
      default: pa_next = PA_OFF;
    endcase
  end

endmodule

// File: doc/tdma_burst_scheduler.md
Name: tdma_burst_scheduler

Overview:
Sequences the GMSK transmit chain onto a TDMA timeslot grid. It sits between the modulator's symbol strobe and the burst controller's fire/arm handshake. It keeps slot, symbol and frame counters, fires bursts ahead of enabled slot boundaries, and drives PA enable around each burst. It reports underruns when the burst controller is not ready.

Parameters:
FIRE_LEAD, 4, symbols before a slot boundary at which the fire decision for the next slot is made
PA_LAG, 2, symbols PA stays enabled after iq_valid_i falls
IQ_TIMEOUT, 8, symbols after fire within which iq_valid_i must rise
FN_WIDTH, 12, frame number width; wraps modulo 2^FN_WIDTH

Ports:
clock  input  1  system clock (PLL domain)
reset  input  1  synchronous, active-high reset
symbol_strobe_i  input  1  one-cycle pulse per symbol from modulator
enable_i  input  1  scheduler run enable
slot_mask_i  input  8  per-slot transmit enable; bit n = slot n
mask_load_i  input  1  one-cycle strobe; captures slot_mask_i into shadow
is_armed_i  input  1  burst controller ready to accept fire
iq_valid_i  input  1  burst controller emitting valid IQ
fire_burst_o  output  1  one-cycle fire pulse to burst controller
pa_enable_o  output  1  PA / RF chain enable
slot_number_o  output  3  current slot 0..7
symbol_in_slot_o  output  8  symbol index within slot
frame_number_o  output  FN_WIDTH  current frame number
frame_start_o  output  1  one-cycle pulse at start of slot 0
underrun_o  output  1  sticky underrun / timeout flag

Behaviour:
- Reset: all outputs 0; active and shadow masks 0; shadow_valid 0; FSMs IDLE / PA_OFF.
- Slot length L(s) = 157 for s = 0 and 4, else 156. Frame = 1250 symbols.
- Run FSM, IDLE -> RUN when enable_i = 1.
  - In IDLE, counters are held at 0 and strobes are ignored.
  - RUN -> IDLE on the cycle after enable_i falls; counters clear to 0 there.
  - Entering RUN: the first strobe advances symbol_in_slot 0 -> 1 in slot 0. No frame_start_o is issued for this initial slot 0, and that slot never transmits.
- Counters change only on clock edges with symbol_strobe_i = 1 in RUN.
  - symbol_in_slot wraps from L(s)-1 to 0 and slot increments.
  - slot wraps 7 -> 0; on that edge frame_number increments (mod 2^FN_WIDTH) and frame_start_o pulses.
- Mask load: mask_load_i writes the shadow register and sets shadow_valid. It also clears underrun_o. It is accepted in any state, and a later load overwrites an earlier one.
- Fire decision: taken on the strobe edge where the new symbol_in_slot = L(s) - FIRE_LEAD. The target slot is t = (s+1) mod 8.
  - If t = 0 and shadow_valid: active <= shadow and shadow_valid <= 0 on that same edge. The decision for t uses the newly committed value.
  - If active[t] = 1 and is_armed_i = 1: fire_burst_o = 1 for exactly one cycle, registered on that edge.
  - If active[t] = 1 and is_armed_i = 0: no fire; underrun_o <= 1.
  - If the PA FSM is not PA_OFF at the decision: no fire; underrun_o <= 1.
- PA FSM:
  - PA_OFF -> WAIT_IQ on fire; pa_enable_o = 1 from that same edge.
  - WAIT_IQ -> ON when iq_valid_i = 1.
  - WAIT_IQ -> PA_OFF after IQ_TIMEOUT strobes without iq_valid_i; this sets underrun_o.
  - ON -> HOLD when iq_valid_i falls.
  - HOLD -> PA_OFF after PA_LAG strobes; pa_enable_o = 0 on that edge.
  - pa_enable_o = 1 in WAIT_IQ, ON and HOLD.
- enable_i falling mid-burst: no further fires. WAIT_IQ and ON go to HOLD, and PA_LAG counts raw strobes.
- Reset overrides everything in the same cycle.
- Simultaneous mask_load_i and commit edge: the commit uses the old shadow; the new value stays pending (shadow_valid = 1).

Test Plan:
- Reset, enable = 1, mask = 0x02 loaded, is_armed_i = 1, strobe every 4 clocks -> fire_burst_o single pulse when slot = 0 and symbol_in_slot = 153; pa_enable_o rises on the same edge.
- Continue, mask = 0x01 loaded during slot 2 -> commit at slot 7, symbol 152; fire there; frame_start_o pulse and frame_number 0 -> 1 at the next slot 7 -> 0 wrap.
- Mask 0x10 with is_armed_i = 0 -> no fire at slot 3, symbol 152; underrun_o = 1; a later mask_load_i clears it.
- Fire, iq_valid_i high 148 symbols then low -> pa_enable_o stays high until 2 strobes after the fall. Repeat with iq_valid_i never rising -> pa_enable_o drops after 8 strobes and underrun_o = 1.
- Run 4096 frames with FN_WIDTH = 12 -> frame_number_o wraps 4095 -> 0. Slot 4 spans 157 symbols and slot 5 spans 156.
- Drop enable_i during ON, then assert reset during HOLD -> all outputs 0 the next cycle, counters 0.
